tug_ctrl: RTL and testbench
===========================

Name: tug_ctrl

Overview:
Game controller for the tug-of-war board. It turns the two players' key presses into pulls and moves a single lit "rope" marker along the LED row. It detects when a point is won, holds the result, re-centres the marker and keeps a per-player score. It sequences the LED playfield and latches the match winner for the HEX/score display logic.

Parameters:
N_LIGHTS, 9, number of playfield LEDs; must be odd and at least 3; centre index is N_LIGHTS/2.
WIN_SCORE, 7, points needed to win the match; must be at least 1.
HOLD_CYCLES, 8, cycles the WIN_HOLD state lasts; must be at least 1; board top level overrides it with a large value.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clock clk
key_l  in  1  left player key, already synchronized, high = pressed
key_r  in  1  right player key, already synchronized, high = pressed
leds  out  N_LIGHTS  playfield; one-hot marker position; index N_LIGHTS-1 is the left end
winner  out  2  00 none, 01 left, 10 right
score_l  out  $clog2(WIN_SCORE+1)  left player points
score_r  out  $clog2(WIN_SCORE+1)  right player points
game_over  out  1  match finished; high only in MATCH_OVER

Behaviour:
- Reset, checked every cycle (it has priority in every state):
  - state = PLAY
  - pos = N_LIGHTS/2, so leds = one-hot of the centre (9'b000010000 with defaults)
  - winner = 00, both scores = 0, game_over = 0
  - hold counter = 0, edge-detector history = 0
- Press detection, one press_edge instance per key:
  - pulse = key & ~key_q, registered.
  - A key first sampled high at edge k gives a pull pulse valid during cycle k+1. The pull acts at edge k+1.
  - Holding a key down produces exactly one pull. The edge detectors run in every state, so a key held through WIN_HOLD produces no pull after it.
- PLAY state:
  - Both pulses in the same cycle: the pulls cancel and nothing changes.
  - Left pulse alone, pos < N_LIGHTS-1: pos <= pos+1.
  - Left pulse alone, pos == N_LIGHTS-1: left scores. score_l increments, winner <= 01, and the block moves to WIN_HOLD, or to MATCH_OVER if the new score equals WIN_SCORE.
  - Right pulse: mirror of the left case. At pos > 0, pos <= pos-1. At pos == 0, right scores and winner <= 10.
  - leds = one-hot(pos); winner = 00.
- WIN_HOLD state:
  - leds = all zeros. winner shows the player who won the point. Pulses are ignored.
  - The hold counter counts 0 .. HOLD_CYCLES-1. On the terminal count: pos <= centre, winner <= 00, counter <= 0, and the block returns to PLAY.
  - The block spends exactly HOLD_CYCLES cycles in WIN_HOLD.
- MATCH_OVER state:
  - leds = all ones. winner stays latched to the match winner. game_over = 1.
  - Scores are frozen and pulses are ignored. Only reset leaves this state.
- Scores:
  - Unsigned and never wrap. An increment happens only on a scoring event, and a score can reach at most WIN_SCORE.
- Outputs:
  - All outputs come from registers or are decoded from registered state only. There is no combinational path from key_* to any output.

Decomposition:
- Package tug_pkg:
  - state enum {PLAY, WIN_HOLD, MATCH_OVER}
  - winner codes WIN_NONE = 2'b00, WIN_LEFT = 2'b01, WIN_RIGHT = 2'b10
- Sub-module press_edge (clk, reset, key, pulse): registered rising-edge detector, instantiated twice.
- tug_ctrl contains the FSM, the position register, the hold counter and the score registers.

Test Plan:
1. Reset, then idle 5 cycles -> leds = 000010000, winner = 00, both scores = 0, game_over = 0.
2. key_l held high for 10 cycles from centre -> exactly one pull; leds = 000100000 and stays there.
3. key_l and key_r rise on the same cycle -> no change; leds = 000010000.
4. Five separate left presses from centre -> the fifth press at pos 8 sends the block to WIN_HOLD: score_l = 1, winner = 01, leds = 0. After exactly 8 cycles -> PLAY, leds = 000010000, winner = 00.
5. Right player scores 7 points -> after the 7th point: MATCH_OVER, leds = all ones, winner = 10, score_r = 7, game_over = 1. Further presses change nothing. Reset returns to the test 1 state.
6. Assert reset during WIN_HOLD (hold counter = 3) -> next cycle in PLAY, centre lit, both scores = 0.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war game controller: FSM states and winner codes.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    WIN_HOLD   = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/press_edge.sv
// Registered rising-edge detector: one pulse per key press, one cycle after the key is first seen high.
module press_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic key_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      key_q <= key;
      pulse <= key & ~key_q;
    end
  end

endmodule

// File: rtl/tug_ctrl.sv
// Tug-of-war game controller: marker position, point hold, scores and match winner.
// All outputs are decoded from registered state; keys reach them only through press_edge.
module tug_ctrl
  import tug_pkg::*;
#(
  parameter int N_LIGHTS    = 9,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           key_l,
  input  logic                           key_r,
  output logic [N_LIGHTS-1:0]            leds,
  output logic [1:0]                     winner,
  output logic [$clog2(WIN_SCORE+1)-1:0] score_l,
  output logic [$clog2(WIN_SCORE+1)-1:0] score_r,
  output logic                           game_over
);

  localparam int POS_W   = $clog2(N_LIGHTS);
  localparam int SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POS_W-1:0]   CENTRE   = POS_W'(N_LIGHTS / 2);
  localparam logic [POS_W-1:0]   LEFT_END = POS_W'(N_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] LAST_PT  = SCORE_W'(WIN_SCORE - 1);
  localparam logic [CNT_W-1:0]   HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);

  state_t             state, state_nx;
  logic [POS_W-1:0]   pos;
  logic [CNT_W-1:0]   hold_cnt;
  logic               pull_l, pull_r;
  logic               move_l, move_r;
  logic               score_evt_l, score_evt_r, hold_done;

  press_edge u_edge_l (.clk(clk), .reset(reset), .key(key_l), .pulse(pull_l));
  press_edge u_edge_r (.clk(clk), .reset(reset), .key(key_r), .pulse(pull_r));

  // Simultaneous pulls cancel out.
  assign move_l      = pull_l & ~pull_r;
  assign move_r      = pull_r & ~pull_l;
  assign score_evt_l = (state == PLAY) && move_l && (pos == LEFT_END);
  assign score_evt_r = (state == PLAY) && move_r && (pos == '0);
  assign hold_done   = (state == WIN_HOLD) && (hold_cnt == HOLD_TC);

  always_ff @(posedge clk) begin
    if (reset) state <= PLAY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      PLAY: begin
        if (score_evt_l)      state_nx = (score_l == LAST_PT) ? MATCH_OVER : WIN_HOLD;
        else if (score_evt_r) state_nx = (score_r == LAST_PT) ? MATCH_OVER : WIN_HOLD;
      end
      WIN_HOLD:   if (hold_done) state_nx = PLAY;
      MATCH_OVER: state_nx = MATCH_OVER;
      default:    state_nx = PLAY;
    endcase
  end

  always_comb begin
    leds      = '0;
    game_over = 1'b0;
    case (state)
      PLAY:       leds = {{(N_LIGHTS-1){1'b0}}, 1'b1} << pos;
      MATCH_OVER: begin
        leds      = '1;
        game_over = 1'b1;
      end
      default:    leds = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos      <= CENTRE;
      hold_cnt <= '0;
      winner   <= WIN_NONE;
      score_l  <= '0;
      score_r  <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (score_evt_l) begin
            score_l <= score_l + SCORE_W'(1);
            winner  <= WIN_LEFT;
          end else if (score_evt_r) begin
            score_r <= score_r + SCORE_W'(1);
            winner  <= WIN_RIGHT;
          end else if (move_l) begin
            pos <= pos + POS_W'(1);
          end else if (move_r) begin
            pos <= pos - POS_W'(1);
          end
        end
        WIN_HOLD: begin
          if (hold_done) begin
            hold_cnt <= '0;
            pos      <= CENTRE;
            winner   <= WIN_NONE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tug_ctrl.sv
// Scoreboard bench for tug_ctrl: directed stimulus queues expected outputs, a negedge monitor checks them.
module tb_tug_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_l, key_r;
  logic [8:0] leds;
  logic [1:0] winner;
  logic [2:0] score_l, score_r;
  logic       game_over;

  typedef struct packed {
    logic [8:0] leds;
    logic [1:0] winner;
    logic [2:0] sl;
    logic [2:0] sr;
    logic       go;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  localparam logic [8:0] CENTRE = 9'b000010000;
  localparam logic [8:0] ALL    = 9'b111111111;
  localparam logic [8:0] NONE   = 9'b000000000;

  tug_ctrl #(.N_LIGHTS(9), .WIN_SCORE(7), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r),
    .leds(leds), .winner(winner), .score_l(score_l), .score_r(score_r),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h at %0t", nm, f, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents its state every cycle; compare whenever an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "leds",      int'(leds),      int'(e.leds));
      chk(nm, "winner",    int'(winner),    int'(e.winner));
      chk(nm, "score_l",   int'(score_l),   int'(e.sl));
      chk(nm, "score_r",   int'(score_r),   int'(e.sr));
      chk(nm, "game_over", int'(game_over), int'(e.go));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [8:0] l, input logic [1:0] w,
                            input logic [2:0] sl, input logic [2:0] sr, input logic go);
    exp_t e;
    e.leds = l; e.winner = w; e.sl = sl; e.sr = sr; e.go = go;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Press for two edges (pulse, then pull), release, and one more edge to clear history.
  task automatic press(input logic l, input logic r);
    key_l = l; key_r = r;
    tick(); tick();
    key_l = 1'b0; key_r = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; key_l = 1'b0; key_r = 1'b0;
    tick(); tick();
    expect_now("reset_held", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_now("idle", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);
    end

    // 2: held key gives exactly one pull
    key_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_now("hold_key", (i == 0) ? CENTRE : 9'b000100000, 2'b00, 3'd0, 3'd0, 1'b0);
    end
    key_l = 1'b0;
    tick(); tick();
    expect_now("hold_key_release", 9'b000100000, 2'b00, 3'd0, 3'd0, 1'b0);

    // 3: simultaneous pulls cancel
    press(1'b0, 1'b1);
    expect_now("right_back", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);
    press(1'b1, 1'b1);
    expect_now("cancel", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);
    tick();
    expect_now("cancel_after", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);

    // 4: left point, key held through the whole hold
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    expect_now("left_end", 9'b100000000, 2'b00, 3'd0, 3'd0, 1'b0);
    key_l = 1'b1;
    tick(); tick();
    expect_now("left_point", NONE, 2'b01, 3'd1, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_now("left_hold", NONE, 2'b01, 3'd1, 3'd0, 1'b0);
    end
    tick();
    expect_now("hold_exit", CENTRE, 2'b00, 3'd1, 3'd0, 1'b0);
    tick(); tick();
    expect_now("held_through_hold", CENTRE, 2'b00, 3'd1, 3'd0, 1'b0);
    key_l = 1'b0;
    tick();

    // 5: right wins the match
    for (int k = 1; k <= 7; k++) begin
      for (int i = 0; i < 4; i++) press(1'b0, 1'b1);
      expect_now("right_end", 9'b000000001, 2'b00, 3'd1, 3'(k - 1), 1'b0);
      key_r = 1'b1;
      tick(); tick();
      key_r = 1'b0;
      if (k < 7) begin
        expect_now("right_point", NONE, 2'b10, 3'd1, 3'(k), 1'b0);
        repeat (7) tick();
        expect_now("right_hold_last", NONE, 2'b10, 3'd1, 3'(k), 1'b0);
        tick();
        expect_now("right_recentre", CENTRE, 2'b00, 3'd1, 3'(k), 1'b0);
      end else begin
        expect_now("match_over", ALL, 2'b10, 3'd1, 3'd7, 1'b1);
      end
    end
    press(1'b1, 1'b0);
    expect_now("over_left_press", ALL, 2'b10, 3'd1, 3'd7, 1'b1);
    press(1'b0, 1'b1);
    expect_now("over_right_press", ALL, 2'b10, 3'd1, 3'd7, 1'b1);
    repeat (10) tick();
    expect_now("over_stays", ALL, 2'b10, 3'd1, 3'd7, 1'b1);
    reset = 1'b1;
    tick();
    expect_now("over_reset", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);
    reset = 1'b0;
    tick();
    expect_now("post_reset", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);

    // 6: reset in the middle of a hold
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    key_l = 1'b1;
    tick(); tick();
    key_l = 1'b0;
    expect_now("hold_cnt0", NONE, 2'b01, 3'd1, 3'd0, 1'b0);
    repeat (3) tick();
    expect_now("hold_cnt3", NONE, 2'b01, 3'd1, 3'd0, 1'b0);
    reset = 1'b1;
    tick();
    expect_now("hold_reset", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);
    reset = 1'b0;
    tick();
    expect_now("hold_reset_after", CENTRE, 2'b00, 3'd0, 3'd0, 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
